// File: rtl/sdr_pkg.sv
// Shared constants, state type and the round/saturate helper for the transmit
// up-converter.
package sdr_pkg;
  localparam int LANES       = 4;
  localparam int BB_W        = 16;
  localparam int TRIG_W      = 16;
  localparam int DAC_W       = 12;
  localparam int ROUND_SHIFT = 20;
  localparam int PROD_W      = BB_W + TRIG_W + 1;

  localparam logic signed [PROD_W-1:0] RND_HALF = PROD_W'(2 ** (ROUND_SHIFT - 1));
  localparam logic signed [PROD_W-1:0] SAT_MAX  = PROD_W'(2 ** (DAC_W - 1) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN  = PROD_W'(-(2 ** (DAC_W - 1)));

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Round half up at bit ROUND_SHIFT, then clamp into the signed DAC range.
  function automatic logic [DAC_W-1:0] round_sat(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W-1:0] r;
    r = (p + RND_HALF) >>> ROUND_SHIFT;
    if (r > SAT_MAX) begin
      round_sat = SAT_MAX[DAC_W-1:0];
    end else if (r < SAT_MIN) begin
      round_sat = SAT_MIN[DAC_W-1:0];
    end else begin
      round_sat = r[DAC_W-1:0];
    end
  endfunction
endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO with a registered ready flag and fill count; flush empties
// it in one clock and discards a push in that same clock.
module tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 128
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push_valid,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic                   ready,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [AW:0]      count_nxt_s;
  logic             ready_r;
  logic             push_s;
  logic             pop_s;

  assign push_s = push_valid & ready_r;
  assign pop_s  = pop & (count_r != {(AW+1){1'b0}});

  // Next fill level, shared by the count and the registered ready flag.
  always_comb begin
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = {(AW+1){1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + (AW+1)'(1);
        2'b01:   count_nxt_s = count_r - (AW+1)'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Pointer, count and ready state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      ready_r  <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
        if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      ready_r <= (count_nxt_s < (AW+1)'(DEPTH));
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s && !flush) mem_r[wr_ptr_r] <= wdata;
  end

  assign ready = ready_r;
  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == {(AW+1){1'b0}});
endmodule

// File: rtl/duc_mixer.sv
// Four-lane digital up-converter: buffered baseband mixed with the per-lane
// oscillator as I*cos - Q*sin, rounded and saturated to 12-bit DAC words.
module duc_mixer
  import sdr_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int PRIME      = 8,
  parameter int OFFSET_BIN = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic                      s_valid_i,
  output logic                      s_ready_o,
  input  logic [LANES*BB_W-1:0]     s_i_i,
  input  logic [LANES*BB_W-1:0]     s_q_i,
  input  logic [LANES-1:0]          osc_valid_i,
  input  logic [LANES*TRIG_W-1:0]   sin_i,
  input  logic [LANES*TRIG_W-1:0]   cos_i,
  output logic [LANES*DAC_W-1:0]    dac_data_o,
  output logic                      dac_valid_o,
  output logic                      busy_o,
  output logic [15:0]               underflow_cnt_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = 2 * LANES * BB_W;
  localparam logic [DAC_W-1:0] MSB_MASK =
    (OFFSET_BIN != 0) ? {1'b1, {(DAC_W-1){1'b0}}} : {DAC_W{1'b0}};

  logic                   tick_s;
  logic                   pop_s;
  logic                   flush_s;
  logic                   underflow_s;
  logic                   empty_s;
  logic [CW-1:0]          count_s;
  logic [FW-1:0]          rdata_s;
  logic [FW-1:0]          sample_s;

  state_t                 state_r;
  logic                   busy_r;
  logic [15:0]            ucnt_r;

  logic signed [BB_W+TRIG_W-1:0] prod_ic_r [LANES];
  logic signed [BB_W+TRIG_W-1:0] prod_qs_r [LANES];
  logic signed [PROD_W-1:0]      diff_r    [LANES];
  logic [LANES*DAC_W-1:0]        dac_r;
  logic                          v1_r;
  logic                          v2_r;
  logic                          dac_valid_r;

  assign tick_s      = &osc_valid_i;
  assign pop_s       = (state_r == RUN) & tick_s & ~empty_s;
  assign underflow_s = (state_r == RUN) & tick_s & empty_s;
  assign flush_s     = (state_r == RUN) & ~enable_i;
  assign sample_s    = pop_s ? rdata_s : {FW{1'b0}};

  tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .flush      (flush_s),
    .push_valid (s_valid_i),
    .pop        (pop_s),
    .wdata      ({s_q_i, s_i_i}),
    .ready      (s_ready_o),
    .rdata      (rdata_s),
    .count      (count_s),
    .empty      (empty_s)
  );

  // Transmit state, busy flag and saturating underflow counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      ucnt_r  <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (enable_i && (count_s >= CW'(PRIME))) begin
            state_r <= RUN;
            busy_r  <= 1'b1;
          end
        end
        RUN: begin
          if (underflow_s || !enable_i) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
      if (underflow_s && (ucnt_r != 16'hFFFF)) ucnt_r <= ucnt_r + 16'h0001;
    end
  end

  // Multiply, subtract, round/saturate; each stage moves only on an oscillator tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int l = 0; l < LANES; l++) begin
        prod_ic_r[l] <= '0;
        prod_qs_r[l] <= '0;
        diff_r[l]    <= '0;
      end
      dac_r       <= {LANES{MSB_MASK}};
      v1_r        <= 1'b0;
      v2_r        <= 1'b0;
      dac_valid_r <= 1'b0;
    end else if (tick_s) begin
      for (int l = 0; l < LANES; l++) begin
        prod_ic_r[l] <= $signed(sample_s[l*BB_W +: BB_W]) * $signed(cos_i[l*TRIG_W +: TRIG_W]);
        prod_qs_r[l] <= $signed(sample_s[LANES*BB_W + l*BB_W +: BB_W]) *
                        $signed(sin_i[l*TRIG_W +: TRIG_W]);
        diff_r[l]    <= PROD_W'(prod_ic_r[l]) - PROD_W'(prod_qs_r[l]);
        dac_r[l*DAC_W +: DAC_W] <= round_sat(diff_r[l]) ^ MSB_MASK;
      end
      v1_r        <= 1'b1;
      v2_r        <= v1_r;
      dac_valid_r <= v2_r;
    end else begin
      dac_valid_r <= 1'b0;
    end
  end

  assign dac_data_o      = dac_r;
  assign dac_valid_o     = dac_valid_r;
  assign busy_o          = busy_r;
  assign underflow_cnt_o = ucnt_r;
endmodule

// File: tb/tb_duc_mixer.sv
// Directed bench for duc_mixer: a two's-complement and an offset-binary
// instance driven from the same stimulus.
module tb_duc_mixer;
  logic        clk = 1'b0;
  logic        rst_ni, enable_i, s_valid_i;
  logic [63:0] s_i_i, s_q_i, sin_i, cos_i;
  logic [3:0]  osc_valid_i;
  logic        s_ready_o, dac_valid_o, busy_o;
  logic [47:0] dac_data_o;
  logic [15:0] underflow_cnt_o;
  logic        s_ready_ob, dac_valid_ob, busy_ob;
  logic [47:0] dac_data_ob;
  logic [15:0] underflow_cnt_ob;

  localparam logic [47:0] OFFS = 48'h800800800800;

  int errors = 0;
  int checks = 0;
  int exp_ucnt = 0;
  logic [63:0] wi [16], wq [16], wc [16], ws [16];
  logic [47:0] ex [16];

  always #5 clk = ~clk;

  duc_mixer #(.DEPTH(16), .PRIME(8), .OFFSET_BIN(0)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o), .s_i_i(s_i_i), .s_q_i(s_q_i), .osc_valid_i(osc_valid_i),
    .sin_i(sin_i), .cos_i(cos_i), .dac_data_o(dac_data_o), .dac_valid_o(dac_valid_o),
    .busy_o(busy_o), .underflow_cnt_o(underflow_cnt_o));

  duc_mixer #(.DEPTH(16), .PRIME(8), .OFFSET_BIN(1)) dut_ob (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_ob), .s_i_i(s_i_i), .s_q_i(s_q_i), .osc_valid_i(osc_valid_i),
    .sin_i(sin_i), .cos_i(cos_i), .dac_data_o(dac_data_ob), .dac_valid_o(dac_valid_ob),
    .busy_o(busy_ob), .underflow_cnt_o(underflow_cnt_ob));

  // Reference mixer written directly from the arithmetic definition.
  function automatic logic [11:0] mix(input logic [15:0] i, q, c, s);
    longint p, r;
    p = longint'($signed(i)) * longint'($signed(c)) - longint'($signed(q)) * longint'($signed(s));
    r = (p + 64'sd524288) >>> 20;
    if (r > 64'sd2047) r = 64'sd2047;
    else if (r < -64'sd2048) r = -64'sd2048;
    return r[11:0];
  endfunction

  task automatic push_word(input logic [63:0] i, input logic [63:0] q, output logic acc);
    s_valid_i = 1'b1; s_i_i = i; s_q_i = q; acc = s_ready_o;
    @(negedge clk);
    s_valid_i = 1'b0;
  endtask

  task automatic push_n(input int n);
    logic acc;
    for (int k = 0; k < n; k++) push_word(wi[k], wq[k], acc);
  endtask

  // Enable with n words queued, check each word three ticks after its pop, then the underflow.
  task automatic test_drain(input int n, input string tag);
    enable_i = 1'b1;
    @(negedge clk);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL %s_busy_rise got %b want 1", tag, busy_o); end
    cos_i = wc[0]; sin_i = ws[0];
    for (int t = 1; t <= n + 3; t++) begin
      @(negedge clk);
      if (t >= 3 && t < n + 3) begin
        checks++;
        if (dac_data_o !== ex[t-3] || dac_valid_o !== 1'b1) begin
          errors++; $display("FAIL %s_word%0d got %h/%b want %h/1", tag, t-3, dac_data_o, dac_valid_o, ex[t-3]);
        end
        checks++;
        if (dac_data_ob !== (ex[t-3] ^ OFFS)) begin
          errors++; $display("FAIL %s_ob_word%0d got %h want %h", tag, t-3, dac_data_ob, ex[t-3] ^ OFFS);
        end
      end
      if (t == n) begin
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL %s_busy_last got %b want 1", tag, busy_o); end
      end
      if (t == n + 1) begin
        exp_ucnt++;
        checks++;
        if (busy_o !== 1'b0 || underflow_cnt_o !== 16'(exp_ucnt)) begin
          errors++; $display("FAIL %s_underflow got busy=%b cnt=%0d want busy=0 cnt=%0d", tag, busy_o, underflow_cnt_o, exp_ucnt);
        end
      end
      if (t < n) begin cos_i = wc[t]; sin_i = ws[t]; end
      else begin cos_i = 64'h0; sin_i = 64'h0; end
    end
    checks++;
    if (dac_data_o !== 48'h0 || dac_data_ob !== OFFS) begin
      errors++; $display("FAIL %s_silence got %h/%h want 0/%h", tag, dac_data_o, dac_data_ob, OFFS);
    end
    enable_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; enable_i = 1'b0; s_valid_i = 1'b0; osc_valid_i = 4'hF;
    s_i_i = 64'h0; s_q_i = 64'h0; sin_i = 64'h0; cos_i = 64'h0;
    repeat (2) @(negedge clk);
    checks++;
    if (s_ready_o !== 1'b0 || dac_data_o !== 48'h0 || dac_valid_o !== 1'b0 || busy_o !== 1'b0 ||
        underflow_cnt_o !== 16'h0 || dac_data_ob !== OFFS) begin
      errors++; $display("FAIL reset_hold got rdy=%b dac=%h v=%b busy=%b cnt=%0d ob=%h want 0 0 0 0 0 %h",
        s_ready_o, dac_data_o, dac_valid_o, busy_o, underflow_cnt_o, dac_data_ob, OFFS);
    end
    rst_ni = 1'b1;
    @(negedge clk);
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", s_ready_o); end
    repeat (4) @(negedge clk);
    checks++;
    if (dac_data_o !== 48'h0 || dac_valid_o !== 1'b1 || busy_o !== 1'b0 || underflow_cnt_o !== 16'h0 ||
        dac_data_ob !== OFFS) begin
      errors++; $display("FAIL idle_out got dac=%h v=%b busy=%b cnt=%0d ob=%h want 0 1 0 0 %h",
        dac_data_o, dac_valid_o, busy_o, underflow_cnt_o, dac_data_ob, OFFS);
    end
  endtask

  task automatic test_dc();
    for (int k = 0; k < 8; k++) begin
      wi[k] = 64'h4000400040004000; wq[k] = 64'h0;
      wc[k] = 64'h7FFF7FFF7FFF7FFF; ws[k] = 64'h0;
      ex[k] = 48'h200200200200;
    end
    push_n(8);
    test_drain(8, "dc");
  endtask

  task automatic test_quadrature();
    logic [15:0] ti [8], tq [8], tc [8], ts [8];
    logic [11:0] te [8];
    ti = '{16'h8000, 16'h7FFF, 16'h8000, 16'h4000, 16'h0800, 16'h0800, 16'hF800, 16'h0000};
    tq = '{16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h4000};
    tc = '{16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h0100, 16'h0100, 16'h0100, 16'h7FFF};
    ts = '{16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h4000};
    te = '{12'h7FF, 12'hC00, 12'h800, 12'h200, 12'h001, 12'h000, 12'hFFF, 12'hF00};
    for (int k = 0; k < 8; k++) begin
      for (int l = 0; l < 4; l++) begin
        wi[k][16*l +: 16] = ti[(k+l)%8]; wq[k][16*l +: 16] = tq[(k+l)%8];
        wc[k][16*l +: 16] = tc[(k+l)%8]; ws[k][16*l +: 16] = ts[(k+l)%8];
        ex[k][12*l +: 12] = te[(k+l)%8];
      end
    end
    push_n(8);
    test_drain(8, "quad");
  endtask

  task automatic build_ramp(input int h);
    for (int k = 0; k < 8; k++) begin
      wi[k] = {16'(-1024*(k+1)), 16'(1024*(k+1)), 16'(-2048*(k+1)), 16'(2048*(k+1))};
      wq[k] = 64'h1234123412341234;
      wc[k] = (h == 0) ? 64'h4000400040004000 : 64'h2000200020002000;
      ws[k] = 64'h0;
      ex[k] = {12'(-(16 >> h)*(k+1)), 12'((16 >> h)*(k+1)), 12'(-(32 >> h)*(k+1)), 12'((32 >> h)*(k+1))};
    end
  endtask

  task automatic test_underflow();
    build_ramp(0);
    push_n(8);
    test_drain(8, "uflow");
    build_ramp(1);
    push_n(8);
    test_drain(8, "refill");
  endtask

  task automatic test_back_to_back();
    logic acc;
    logic [63:0] bi, bq;
    enable_i = 1'b0;
    for (int k = 0; k < 18; k++) begin
      for (int l = 0; l < 4; l++) begin
        bi[16*l +: 16] = 16'(k*5003 + l*12345 + 1000);
        bq[16*l +: 16] = 16'(k*3001 + l*999 + 77) ^ 16'h8000;
      end
      if (k < 16) begin
        wi[k] = bi; wq[k] = bq;
        for (int l = 0; l < 4; l++) begin
          wc[k][16*l +: 16] = 16'(k*7919 + l*1111 + 17185);
          ws[k][16*l +: 16] = 16'(40000 - k*2111 - l*333);
          ex[k][12*l +: 12] = mix(bi[16*l +: 16], bq[16*l +: 16], wc[k][16*l +: 16], ws[k][16*l +: 16]);
        end
      end
      push_word(bi, bq, acc);
      checks++;
      if (acc !== (k < 16)) begin errors++; $display("FAIL full_ready push%0d got %b want %b", k, acc, k < 16); end
    end
    test_drain(16, "full");
  endtask

  task automatic test_enable_drop();
    build_ramp(0);
    push_n(7);
    enable_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL prime_minus1 got busy=%b want 0", busy_o); end
    enable_i = 1'b0;
    begin logic acc; push_word(wi[7], wq[7], acc); end
    cos_i = wc[0]; sin_i = ws[0];
    enable_i = 1'b1;
    @(negedge clk);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL drop_start got busy=%b want 1", busy_o); end
    repeat (2) @(negedge clk);
    enable_i = 1'b0; osc_valid_i = 4'h0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || dac_valid_o !== 1'b0) begin
      errors++; $display("FAIL drop_idle got busy=%b v=%b want 0 0", busy_o, dac_valid_o);
    end
    osc_valid_i = 4'hF;
    @(negedge clk);
    checks++; if (dac_data_o !== ex[0]) begin errors++; $display("FAIL drop_inflight0 got %h want %h", dac_data_o, ex[0]); end
    @(negedge clk);
    checks++; if (dac_data_o !== ex[1]) begin errors++; $display("FAIL drop_inflight1 got %h want %h", dac_data_o, ex[1]); end
    @(negedge clk);
    checks++; if (dac_data_o !== 48'h0) begin errors++; $display("FAIL drop_zeros got %h want 0", dac_data_o); end
    push_n(2);
    enable_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || underflow_cnt_o !== 16'(exp_ucnt)) begin
      errors++; $display("FAIL drop_flushed got busy=%b cnt=%0d want 0 %0d", busy_o, underflow_cnt_o, exp_ucnt);
    end
    enable_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    build_ramp(0);
    push_n(8);
    enable_i = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_running got busy=%b want 1", busy_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (s_ready_o !== 1'b0 || dac_data_o !== 48'h0 || dac_valid_o !== 1'b0 || busy_o !== 1'b0 ||
        underflow_cnt_o !== 16'h0 || dac_data_ob !== OFFS) begin
      errors++; $display("FAIL mid_reset got rdy=%b dac=%h v=%b busy=%b cnt=%0d ob=%h want 0 0 0 0 0 %h",
        s_ready_o, dac_data_o, dac_valid_o, busy_o, underflow_cnt_o, dac_data_ob, OFFS);
    end
    exp_ucnt = 0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", s_ready_o); end
    repeat (3) @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_fifo_cleared got busy=%b want 0", busy_o); end
    enable_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_dc();
    test_quadrature();
    test_underflow();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
